grid_line_clear: RTL

Parametrised line-clear engine for the Tetris grid memory. After the grid controller locks a piece, it pulses `start`. The engine then scans the grid from the bottom row to the top and detects fully occupied rows. Each full row is collapsed by shifting every row above it down by one, and the top row is cleared. The engine drives the same single-port grid memory interface as the grid controller (address, data out, write enable, synchronous read data in), and the top level muxes the port to it while `busy`.

---
 rtl/grid_line_clear_if.sv | 38 +++
 rtl/grid_line_clear.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/grid_line_clear_if.sv
// Grid memory port and pass handshake shared by the line-clear engine and its controller.
// The engine side uses the master modport; the controller/memory side uses slave.
interface grid_line_clear_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 5
);
    logic              start;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  lines_cleared;
    logic [ADDR_W-1:0] grid_address;
    logic [DATA_W-1:0] grid_data_out;
    logic              write_en;
    logic [DATA_W-1:0] tetris_grid_in;

    modport master (
        input  start,
        input  tetris_grid_in,
        output busy,
        output done,
        output lines_cleared,
        output grid_address,
        output grid_data_out,
        output write_en
    );

    modport slave (
        output start,
        output tetris_grid_in,
        input  busy,
        input  done,
        input  lines_cleared,
        input  grid_address,
        input  grid_data_out,
        input  write_en
    );
endinterface

// File: rtl/grid_line_clear.sv
// Line-clear engine: scans the grid bottom-up, collapses full rows and rescans in place.
// Define GRID_LC_SCORE_EN to add the 16-bit saturating score output.
module grid_line_clear #(
    parameter int unsigned GRID_W = 10,
    parameter int unsigned GRID_H = 22,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    grid_line_clear_if.master bus
`ifdef GRID_LC_SCORE_EN
    ,
    output logic [15:0]       score
`endif
);

    localparam int unsigned ROW_W = (GRID_H > 1) ? $clog2(GRID_H) : 1;
    localparam int unsigned COL_W = (GRID_W > 1) ? $clog2(GRID_W) : 1;
    localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(GRID_H - 1);
    localparam logic [COL_W-1:0]  LAST_COL = COL_W'(GRID_W - 1);
    localparam logic [ADDR_W-1:0] ROW_PITCH = ADDR_W'(GRID_W);

    typedef enum logic [2:0] {
        StIdle,
        StScan,
        StEval,
        StShiftRd,
        StShiftWr,
        StClearTop,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [ROW_W-1:0] src_q, src_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;

    logic             cell_ok;
    logic             row_full;
    logic [ROW_W-1:0] addr_row;
    logic [COL_W-1:0] addr_col;

    assign cell_ok  = (bus.tetris_grid_in != '0);
    // The last cell of a row is still in flight when EVAL starts
    assign row_full = full_q & cell_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            row_q   <= '0;
            src_q   <= '0;
            col_q   <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            src_q   <= src_d;
            col_q   <= col_d;
            count_q <= count_d;
            full_q  <= full_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        row_d             = row_q;
        src_d             = src_q;
        col_d             = col_q;
        count_d           = count_q;
        full_d            = full_q;
        addr_row          = '0;
        addr_col          = '0;
        bus.busy          = 1'b0;
        bus.done          = 1'b0;
        bus.write_en      = 1'b0;
        bus.grid_data_out = '0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StScan;
                    row_d   = LAST_ROW;
                    col_d   = '0;
                    count_d = '0;
                end
            end
            StScan: begin
                bus.busy = 1'b1;
                addr_row = row_q;
                addr_col = col_q;
                // Read data arriving in the col-0 cycle belongs to an earlier access
                full_d   = (col_q == '0) ? 1'b1 : (full_q & cell_ok);
                if (col_q == LAST_COL) begin
                    col_d   = '0;
                    state_d = StEval;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            StEval: begin
                bus.busy = 1'b1;
                col_d    = '0;
                if (row_full) begin
                    count_d = (count_q == '1) ? count_q : count_q + 1'b1;
                    if (row_q != '0) begin
                        src_d   = row_q - 1'b1;
                        state_d = StShiftRd;
                    end else begin
                        state_d = StClearTop;
                    end
                end else if (row_q != '0) begin
                    row_d   = row_q - 1'b1;
                    state_d = StScan;
                end else begin
                    state_d = StDone;
                end
            end
            StShiftRd: begin
                bus.busy = 1'b1;
                addr_row = src_q;
                addr_col = col_q;
                state_d  = StShiftWr;
            end
            StShiftWr: begin
                bus.busy          = 1'b1;
                addr_row          = src_q + 1'b1;
                addr_col          = col_q;
                bus.write_en      = 1'b1;
                bus.grid_data_out = bus.tetris_grid_in;
                if (col_q == LAST_COL) begin
                    col_d = '0;
                    if (src_q == '0) begin
                        state_d = StClearTop;
                    end else begin
                        src_d   = src_q - 1'b1;
                        state_d = StShiftRd;
                    end
                end else begin
                    col_d   = col_q + 1'b1;
                    state_d = StShiftRd;
                end
            end
            StClearTop: begin
                bus.busy     = 1'b1;
                addr_col     = col_q;
                bus.write_en = 1'b1;
                if (col_q == LAST_COL) begin
                    // Rescan the same row: the row above has just dropped into it
                    col_d   = '0;
                    state_d = StScan;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            StDone: begin
                bus.done = 1'b1;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.grid_address  = ADDR_W'(addr_row) * ROW_PITCH + ADDR_W'(addr_col);
    assign bus.lines_cleared = count_q;

`ifdef GRID_LC_SCORE_EN
    logic [15:0] score_q, score_d;
    logic [15:0] score_inc;
    logic [16:0] score_sum;

    always_comb begin
        score_inc = 16'd0;
        case (32'(count_q))
            0:       score_inc = 16'd0;
            1:       score_inc = 16'd40;
            2:       score_inc = 16'd100;
            3:       score_inc = 16'd300;
            default: score_inc = 16'd1200;
        endcase
        score_sum = {1'b0, score_q} + {1'b0, score_inc};
        score_d   = score_q;
        if (state_q == StDone) begin
            score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            score_q <= 16'd0;
        end else begin
            score_q <= score_d;
        end
    end

    assign score = score_q;
`endif

endmodule
